// File: rtl/motor_speed_sched.sv
// rtl/motor_speed_sched.sv - motor duty ramp scheduler with hold timer and PWM output
module motor_speed_sched #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int STEP_MS   = 10,
    parameter int DUTY_STEP = 8,
    parameter int HOLD_MS   = 1000
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic [6:0] direction,
    input  logic       start_milli_timer,
    input  logic       start_timer,
    output logic       accelerated,
    output logic       decelerated,
    output logic       timer_expire,
    output logic [7:0] duty,
    output logic       pwm
);

    localparam int PRE_CNT = CLK_HZ / 1000;
    localparam int PRE_W   = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
    localparam int STEP_W  = $clog2(STEP_MS + 1);
    localparam int HOLD_W  = $clog2(HOLD_MS + 1);

    localparam logic [6:0] DIR_FORWARD = 7'b0000001;
    localparam logic [6:0] DIR_IDLE    = 7'b0000010;
    localparam logic [6:0] DIR_ACC     = 7'b0100000;

    typedef enum logic [1:0] {
        AT_SPEED  = 2'd0,
        RAMP_DOWN = 2'd1,
        STOPPED   = 2'd2,
        RAMP_UP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_q;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [7:0]          duty_q, duty_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [7:0]          pwm_cnt_q;
    logic                accel_q, decel_q, expire_q, expire_d, pwm_q;
    logic                ms_tick;
    logic [8:0]          sum9;

    assign ms_tick = (pre_q == PRE_W'(PRE_CNT - 1));
    assign sum9    = {1'b0, duty_q} + 9'(DUTY_STEP);

    // A valid ramp request takes priority over a coincident step so the
    // restarted ramp always begins from the duty currently being driven.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        duty_d  = duty_q;
        if (start_milli_timer && (direction == DIR_FORWARD || direction == DIR_ACC)) begin
            state_d = RAMP_DOWN;
            step_d  = '0;
        end else if (start_milli_timer && direction == DIR_IDLE) begin
            state_d = RAMP_UP;
            step_d  = '0;
        end else if ((state_q == RAMP_UP || state_q == RAMP_DOWN) && ms_tick) begin
            if (step_q == STEP_W'(STEP_MS - 1)) begin
                step_d = '0;
                if (state_q == RAMP_UP) begin
                    if (sum9 >= 9'd255) begin
                        duty_d  = 8'd255;
                        state_d = AT_SPEED;
                    end else begin
                        duty_d = sum9[7:0];
                    end
                end else begin
                    if ({1'b0, duty_q} <= 9'(DUTY_STEP)) begin
                        duty_d  = 8'd0;
                        state_d = STOPPED;
                    end else begin
                        duty_d = duty_q - 8'(DUTY_STEP);
                    end
                end
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    // A start coincident with the final decrement reloads and suppresses the expiry.
    always_comb begin
        hold_d   = hold_q;
        expire_d = 1'b0;
        if (start_timer) begin
            hold_d = HOLD_W'(HOLD_MS);
        end else if (ms_tick && hold_q != '0) begin
            hold_d   = hold_q - HOLD_W'(1);
            expire_d = (hold_q == HOLD_W'(1));
        end
    end

    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            pre_q     <= '0;
            state_q   <= AT_SPEED;
            step_q    <= '0;
            duty_q    <= 8'd255;
            hold_q    <= '0;
            pwm_cnt_q <= 8'd0;
            accel_q   <= 1'b1;
            decel_q   <= 1'b0;
            expire_q  <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            pre_q     <= ms_tick ? '0 : pre_q + PRE_W'(1);
            state_q   <= state_d;
            step_q    <= step_d;
            duty_q    <= duty_d;
            hold_q    <= hold_d;
            pwm_cnt_q <= (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
            accel_q   <= (state_d == AT_SPEED);
            decel_q   <= (state_d == STOPPED);
            expire_q  <= expire_d;
            pwm_q     <= (pwm_cnt_q < duty_q);
        end
    end

    assign accelerated  = accel_q;
    assign decelerated  = decel_q;
    assign timer_expire = expire_q;
    assign duty         = duty_q;
    assign pwm          = pwm_q;

endmodule

// File: doc/motor_speed_sched.md
MOTOR_SPEED_SCHED -- requirements
Module: motor_speed_sched

Interface
REQ-001 Parameters (name, default, meaning), one per line SHALL be:
  CLK_HZ  100_000_000  clkin frequency in Hz
  STEP_MS  10  ms ticks per duty step
  DUTY_STEP  8  duty increment/decrement per step
  HOLD_MS  1000  hold-timer length in ms ticks
REQ-002 Ports (name direction width meaning) SHALL be:
  clkin  in  1  system clock, one clock domain
  reset  in  1  asynchronous, active-low reset
  direction  in  7  one-hot motor state (FORWARD=0000001, IDLE=0000010, ACC=0100000)
  start_milli_timer  in  1  ramp request, one-cycle pulse
  start_timer  in  1  hold-timer start, one-cycle pulse
  accelerated  out  1  duty at full speed, level
  decelerated  out  1  duty at zero, level
  timer_expire  out  1  hold timer done, one-cycle pulse
  duty  out  8  current motor duty, 0..255
  pwm  out  1  registered PWM of duty

Function
REQ-003 A free-running prescaler SHALL count 0..CLK_HZ/1000-1 and assert internal ms_tick for one cycle at the terminal count.
REQ-004 The ramp FSM SHALL have four states: AT_SPEED, RAMP_DOWN, STOPPED, RAMP_UP.
REQ-005 On start_milli_timer with direction FORWARD or ACC, the FSM SHALL enter RAMP_DOWN; with direction IDLE, it SHALL enter RAMP_UP; with any other direction, the pulse SHALL be ignored.
REQ-006 Entering a ramp state SHALL clear the step counter; each ms_tick SHALL increment it; at STEP_MS ticks, a duty step SHALL occur and the counter SHALL clear.
REQ-007 RAMP_UP step: duty = min(duty+DUTY_STEP, 255), computed 9 bits wide; when the result is 255, the FSM SHALL enter AT_SPEED.
REQ-008 RAMP_DOWN step: duty = max(duty-DUTY_STEP, 0), without underflow; when the result is 0, the FSM SHALL enter STOPPED.
REQ-009 accelerated SHALL be 1 only in AT_SPEED; decelerated SHALL be 1 only in STOPPED; both SHALL be registered state decodes.
REQ-010 A start_milli_timer during a ramp SHALL re-evaluate per REQ-005 and continue from the current duty, with no duty jump.
REQ-011 Requests SHALL be idempotent: RAMP_UP while at 255 SHALL return to AT_SPEED at the next step; RAMP_DOWN at 0 SHALL return to STOPPED at the next step.
REQ-012 Hold timer: start_timer SHALL load HOLD_MS; each ms_tick SHALL decrement it while nonzero; the transition 1->0 SHALL pulse timer_expire for exactly one cycle.
REQ-013 start_timer coincident with the 1->0 transition SHALL reload, and timer_expire SHALL NOT pulse.
REQ-014 start_timer while the timer is running SHALL restart the count from HOLD_MS.
REQ-015 The PWM counter SHALL count 0..254 and wrap; pwm SHALL register (pwm_cnt < duty), so duty 255 gives constant 1 and duty 0 gives constant 0.
REQ-016 The hold timer and ramp FSM SHALL operate independently; simultaneous requests to both SHALL both be honoured in the same cycle.

Reset
REQ-017 reset low SHALL, without a clock edge, set: FSM=AT_SPEED, duty=255, accelerated=1, decelerated=0, timer_expire=0, pwm=0, and all counters to 0.
REQ-018 Reset asserted mid-ramp or mid-hold SHALL abandon the operation; no timer_expire SHALL pulse after release.

Verification (CLK_HZ=10_000, STEP_MS=2, DUTY_STEP=64, HOLD_MS=3; 10 cycles/ms)
REQ-019 Reset release -> duty=255, accelerated=1, decelerated=0, timer_expire=0, pwm=0 in the first cycle, and pwm=1 thereafter.
REQ-020 direction=FORWARD with a start_milli_timer pulse -> accelerated falls next cycle; duty steps 191, 127, 63, 0; decelerated rises 71..80 cycles after the pulse.
REQ-021 From STOPPED, direction=IDLE with a pulse -> duty steps 64, 128, 192, 255 (saturated); accelerated rises 71..80 cycles after the pulse.
REQ-022 start_timer pulse -> one timer_expire pulse 21..30 cycles later; a second start_timer 15 cycles after the first -> a single expire, 21..30 cycles after the second.
REQ-023 During RAMP_DOWN at duty 127, a pulse with direction=IDLE -> next step 191, decelerated never asserts, and AT_SPEED is reached after 255.
REQ-024 reset low mid-ramp at duty 127 with the hold timer running -> outputs immediately take REQ-017 values, and no timer_expire pulse occurs after release.
